// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types for the decode/issue sequencer: a trimmed scoreboard entry,
// exception record, functional-unit encoding, FSM states and FIFO slot.
package decode_issue_ctrl_pkg;

    localparam int ISSUE_FIFO_DEPTH = 2;

    typedef enum logic [3:0] {
        NONE      = 4'd0,
        LOAD      = 4'd1,
        STORE     = 4'd2,
        ALU       = 4'd3,
        CTRL_FLOW = 4'd4,
        MULT      = 4'd5,
        CSR       = 4'd6
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        fu_t         fu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        is_compressed;
        exception_t  ex;
    } scoreboard_entry_t;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        WAIT_SERIAL = 2'd1,
        WAIT_FLUSH  = 2'd2
    } issue_ctrl_state_e;

    // One FIFO slot: the decoded entry plus the decoder's control-flow flag.
    typedef struct packed {
        scoreboard_entry_t entry;
        logic              is_ctrl_flow;
    } issue_slot_t;

    // CSR-class entries without an exception must drain before anything else decodes.
    function automatic logic needs_serial(scoreboard_entry_t e);
        return (e.fu == CSR) && !e.ex.valid;
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch-side and issue-side handshakes of the decode/issue sequencer.
interface decode_issue_ctrl_if;
    import decode_issue_ctrl_pkg::*;

    logic              fetch_valid_i;
    logic              fetch_ready_o;
    logic [31:0]       fetch_instr_i;
    logic [63:0]       fetch_pc_i;
    logic              fetch_is_compressed_i;
    exception_t        fetch_ex_i;
    logic              issue_valid_o;
    logic              issue_ready_i;
    scoreboard_entry_t issue_entry_o;
    logic              issue_is_ctrl_flow_o;

    // Environment side: drives fetch, consumes issue.
    modport master (
        output fetch_valid_i, fetch_instr_i, fetch_pc_i, fetch_is_compressed_i, fetch_ex_i,
        input  fetch_ready_o,
        input  issue_valid_o, issue_entry_o, issue_is_ctrl_flow_o,
        output issue_ready_i
    );

    // Sequencer side.
    modport slave (
        input  fetch_valid_i, fetch_instr_i, fetch_pc_i, fetch_is_compressed_i, fetch_ex_i,
        output fetch_ready_o,
        output issue_valid_o, issue_entry_o, issue_is_ctrl_flow_o,
        input  issue_ready_i
    );
endinterface

// File: rtl/decode_issue_ctrl_issue_fifo.sv
// Small registered FIFO holding decoded entries until the issue stage takes them.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module issue_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    T            r_mem [DEPTH];

    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign data_o  = r_mem[r_rptr[AW-1:0]];

    // Pointer update; flush drops everything including a same-cycle push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push_i) r_wptr <= r_wptr + (AW+1)'(1);
            if (pop_i)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage write at the tail; cleared on reset so the head reads zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (push_i && !flush_i) begin
            r_mem[r_wptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue sequencer: one decode register feeding the external decoder,
// an issue FIFO capturing its output, CSR serialisation, halt-on-exception
// until flush, and two wrapping performance counters.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = ISSUE_FIFO_DEPTH,
    parameter int CNT_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    decode_issue_ctrl_if.slave  bus,
    output logic [31:0]         dec_instr_o,
    output logic [63:0]         dec_pc_o,
    output logic                dec_is_compressed_o,
    output exception_t          dec_ex_o,
    input  scoreboard_entry_t   dec_entry_i,
    input  logic                dec_is_ctrl_flow_i,
    input  logic                serial_done_i,
    output logic                busy_o,
    output logic [CNT_W-1:0]    decoded_cnt_o,
    output logic [CNT_W-1:0]    serial_stall_cnt_o
);
    issue_ctrl_state_e r_state, w_state_nxt;

    logic        r_d_valid;
    logic [31:0] r_d_instr;
    logic [63:0] r_d_pc;
    logic        r_d_compressed;
    exception_t  r_d_ex;

    logic        w_push, w_pop, w_fetch_fire, w_can_push;
    logic        w_full, w_empty;
    issue_slot_t w_push_slot, w_head;

    assign w_pop        = bus.issue_valid_o && bus.issue_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_can_push   = !w_full || w_pop;
    assign w_push       = r_d_valid && w_can_push && (r_state == RUN) && !flush_i;
    assign bus.fetch_ready_o = !flush_i && !rst_i && (!r_d_valid || w_push);
    assign w_fetch_fire = bus.fetch_valid_i && bus.fetch_ready_o;

    assign w_push_slot.entry        = dec_entry_i;
    assign w_push_slot.is_ctrl_flow = dec_is_ctrl_flow_i;

    assign dec_instr_o         = r_d_instr;
    assign dec_pc_o            = r_d_pc;
    assign dec_is_compressed_o = r_d_compressed;
    assign dec_ex_o            = r_d_ex;

    assign bus.issue_valid_o        = !w_empty;
    assign bus.issue_entry_o        = w_head.entry;
    assign bus.issue_is_ctrl_flow_o = w_head.is_ctrl_flow;

    assign busy_o = (r_state != RUN) || r_d_valid || !w_empty;

    issue_fifo #(
        .DEPTH (DEPTH),
        .T     (issue_slot_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_push),
        .data_i  (w_push_slot),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Decode register: load on accept, empty after push unless refilled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_d_valid      <= 1'b0;
            r_d_instr      <= '0;
            r_d_pc         <= '0;
            r_d_compressed <= 1'b0;
            r_d_ex         <= '0;
        end else if (flush_i) begin
            r_d_valid <= 1'b0;
        end else if (w_fetch_fire) begin
            r_d_valid      <= 1'b1;
            r_d_instr      <= bus.fetch_instr_i;
            r_d_pc         <= bus.fetch_pc_i;
            r_d_compressed <= bus.fetch_is_compressed_i;
            r_d_ex         <= bus.fetch_ex_i;
        end else if (w_push) begin
            r_d_valid <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    // Next state: exceptions halt until flush, CSRs wait for commit.
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_push && dec_entry_i.ex.valid)     w_state_nxt = WAIT_FLUSH;
                    else if (w_push && needs_serial(dec_entry_i)) w_state_nxt = WAIT_SERIAL;
                end
                WAIT_SERIAL: if (serial_done_i) w_state_nxt = RUN;
                WAIT_FLUSH:  w_state_nxt = WAIT_FLUSH;
                default:     w_state_nxt = RUN;
            endcase
        end
    end

    // Performance counters; flush leaves them alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            decoded_cnt_o      <= '0;
            serial_stall_cnt_o <= '0;
        end else begin
            if (w_push) decoded_cnt_o <= decoded_cnt_o + CNT_W'(1);
            if ((r_state == WAIT_SERIAL) && r_d_valid)
                serial_stall_cnt_o <= serial_stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Sequences the decoder between the fetch interface and the issue stage.
- Holds one fetched instruction in a decode register that drives the (combinational) decoder, then captures the decoder's scoreboard entry into a small issue FIFO.
- Enforces serialisation after CSR-class instructions and a halt after exception-carrying entries until flush.
- Provides simple performance counters.

Parameters:
- DEPTH, 2, issue FIFO entries; power of two, ≥2.
- CNT_W, 32, width of performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- flush_i  in  1  pipeline flush from controller
- fetch_valid_i  in  1  fetch entry valid
- fetch_ready_o  out  1  fetch entry accepted when valid&ready
- fetch_instr_i  in  32  instruction (already decompressed)
- fetch_pc_i  in  64  PC
- fetch_is_compressed_i  in  1  originally compressed
- fetch_ex_i  in  exception_t  fetch exception
- dec_instr_o  out  32  to decoder instruction_i
- dec_pc_o  out  64  to decoder pc_i
- dec_is_compressed_o  out  1  to decoder is_compressed_i
- dec_ex_o  out  exception_t  to decoder ex_i
- dec_entry_i  in  scoreboard_entry_t  decoder instruction_o
- dec_is_ctrl_flow_i  in  1  decoder is_control_flow_instr_o
- issue_valid_o  out  1  FIFO head valid
- issue_ready_i  in  1  issue stage accepts head
- issue_entry_o  out  scoreboard_entry_t  FIFO head entry
- issue_is_ctrl_flow_o  out  1  FIFO head control-flow flag
- serial_done_i  in  1  pulse: serialising instruction committed
- busy_o  out  1  state != RUN or D valid or FIFO non-empty
- decoded_cnt_o  out  CNT_W  entries pushed into FIFO, wraps
- serial_stall_cnt_o  out  CNT_W  cycles in WAIT_SERIAL with D valid, wraps

Behaviour:
- Reset (async, rst_i=1):
  - D valid=0; dec_* outputs=0; FIFO empty; issue_valid_o=0; state=RUN.
  - Counters=0; fetch_ready_o=0 while rst_i high.
- D register:
  - Loads fetch_* on fetch_valid_i & fetch_ready_o.
  - dec_* outputs are driven from D only (never from fetch_* combinationally).
- push = D valid & FIFO not full & state==RUN & !flush_i.
  - Captures {dec_entry_i, dec_is_ctrl_flow_i} into FIFO tail.
  - Clears D unless reloaded in the same cycle.
- fetch_ready_o = !flush_i & !rst_i & (!D valid | push). Allows back-to-back throughput of 1/cycle.
- Latency: fetch accept cycle N → pushed end of N+1 at earliest → issue_valid_o high in N+2 (empty FIFO, RUN).
- Pop: issue_valid_o & issue_ready_i. Simultaneous push and pop is allowed when full (pop frees slot same cycle). Pointers wrap modulo DEPTH.
- State machine:
  - RUN → WAIT_SERIAL when pushed entry has fu==CSR and ex.valid==0.
  - RUN → WAIT_FLUSH when pushed entry has ex.valid==1.
  - WAIT_SERIAL → RUN on serial_done_i. Pushes resume the following cycle.
  - WAIT_FLUSH → RUN only on flush_i. serial_done_i is ignored in WAIT_FLUSH.
  - serial_done_i in RUN is ignored.
- flush_i (any state):
  - Next cycle: D valid=0, FIFO empty, state=RUN.
  - No push and no fetch accept in the flush cycle.
  - issue_valid_o may still show the head in the flush cycle; a pop in that cycle is legal.
  - Counters are not cleared.
- Counters:
  - decoded_cnt_o += 1 per push.
  - serial_stall_cnt_o += 1 per cycle with state==WAIT_SERIAL & D valid.
  - Both wrap at 2^CNT_W.
- issue_entry_o/issue_is_ctrl_flow_o hold stable while issue_valid_o & !issue_ready_i.

Decomposition:
- ariane_pkg: reuse scoreboard_entry_t, exception_t, fu_t. Add the typedef issue_ctrl_state_e {RUN, WAIT_SERIAL, WAIT_FLUSH} and the constant ISSUE_FIFO_DEPTH=2.
- One sub-module: issue_fifo. Parameterised by DEPTH and entry type; push/pop/flush, full/empty, registered storage.

Test Plan:
- Stream 4 ADD (0x00208033) back-to-back, issue_ready_i=1 → first issue_valid_o in cycle 2 after accept, then 1/cycle; decoded_cnt_o=4.
- Hold issue_ready_i=0, send 4 instrs → 2 in FIFO, 1 in D, fetch_ready_o=0. Raise ready → all issued in order, no loss or duplication.
- CSRRW (0x34029073) then ADD → ADD held in D; serial_stall_cnt_o counts. Pulse serial_done_i at cycle k → ADD pushed at k+1.
- Entry with fetch_ex_i.valid=1 → state WAIT_FLUSH, serial_done_i ignored, fetch stalls. flush_i → FIFO empty, state RUN next cycle.
- flush_i with full FIFO, D valid and simultaneous fetch_valid_i → nothing accepted; next cycle issue_valid_o=0, fetch_ready_o=1.
- Assert rst_i mid-stream (async, between edges) → all outputs zero immediately. Counters=0 after release.
